// File: rtl/kronos_mem_responder_if.sv
// Kronos native req/ack memory bus: initiator drives the request side,
// the memory responder returns a single-cycle ack with data/error.
interface kronos_mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        wr_en;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, wdata, mask, wr_en,
    input  ack, rdata, err
  );

  modport slave (
    input  req, addr, wdata, mask, wr_en,
    output ack, rdata, err
  );
endinterface

// File: rtl/kronos_mem_responder.sv
// Word-organised SRAM responder for the Kronos req/ack bus with a fixed
// number of wait states, byte-masked writes and a bench preload port.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction outstanding
// WAIT   | transaction captured, counting down wait states (bus ignored)
// ACK    | ack_o high this cycle; a new request may be captured here
module kronos_mem_responder #(
  parameter int unsigned    DEPTH_WORDS = 4096,
  parameter logic [31:0]    BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned    WAIT_CYCLES = 0,
  parameter logic [31:0]    ERR_RDATA   = 32'hDEAD_BEEF,
  localparam int unsigned   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  kronos_mem_responder_if.slave     bus,
  input  logic                      ld_we_i,
  input  logic [AW-1:0]             ld_addr_i,
  input  logic [31:0]               ld_wdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic          we_q, we_d;
  logic          inr_q, inr_d;

  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Decode of the live bus address (32-bit wrapping offset from the base).
  logic [31:0]   in_off;
  logic          in_inr;
  logic [AW-1:0] in_idx;
  assign in_off = bus.addr - BASE_ADDR;
  assign in_inr = ({1'b0, in_off} < SPAN);
  assign in_idx = in_off[AW+1:2];

  // Transaction that acks next: the captured copy once we have waited,
  // otherwise the one being sampled off the bus right now.
  logic          from_cap;
  logic [AW-1:0] e_idx;
  logic [31:0]   e_wdata;
  logic [3:0]    e_mask;
  logic          e_we;
  logic          e_inr;
  logic          commit;
  assign from_cap = (state_q == S_WAIT);
  assign e_idx    = from_cap ? idx_q   : in_idx;
  assign e_wdata  = from_cap ? wdata_q : bus.wdata;
  assign e_mask   = from_cap ? mask_q  : bus.mask;
  assign e_we     = from_cap ? we_q    : bus.wr_en;
  assign e_inr    = from_cap ? inr_q   : in_inr;

  // State, countdown, captured request and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      inr_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      inr_q   <= inr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state: capture in IDLE/ACK, count down in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    we_d    = we_q;
    inr_d   = inr_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (bus.req) begin
          idx_d   = in_idx;
          wdata_d = bus.wdata;
          mask_d  = bus.mask;
          we_d    = bus.wr_en;
          inr_d   = in_inr;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Outputs for the coming cycle; writes commit on the edge that raises ack.
  always_comb begin
    ack_d   = (state_d == S_ACK);
    rdata_d = '0;
    err_d   = 1'b0;
    commit  = 1'b0;
    if (ack_d) begin
      err_d = !e_inr;
      if (e_we) commit  = e_inr && rst_ni;
      else      rdata_d = e_inr ? mem_q[e_idx] : ERR_RDATA;
    end
  end

  // Memory array (not reset); preload is written last so it wins a collision.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (e_mask[b]) mem_q[e_idx][8*b +: 8] <= e_wdata[8*b +: 8];
      end
    end
    if (ld_we_i) mem_q[ld_addr_i] <= ld_wdata_i;
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_kronos_mem_responder.sv
module tb_kronos_mem_responder;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t q0[$];
  exp_t q3[$];

  logic          ld_we0 = 1'b0, ld_we3 = 1'b0;
  logic [AW-1:0] ld_addr0 = '0, ld_addr3 = '0;
  logic [31:0]   ld_wdata0 = '0, ld_wdata3 = '0;

  kronos_mem_responder_if m0 ();
  kronos_mem_responder_if m3 ();

  kronos_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0),
                         .ERR_RDATA(32'hDEAD_BEEF)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(m0.slave),
    .ld_we_i(ld_we0), .ld_addr_i(ld_addr0), .ld_wdata_i(ld_wdata0));

  kronos_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3),
                         .ERR_RDATA(32'hDEAD_BEEF)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(m3.slave),
    .ld_we_i(ld_we3), .ld_addr_i(ld_addr3), .ld_wdata_i(ld_wdata3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per ack cycle.
  always @(negedge clk) begin
    if (rst_ni && m0.ack === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected ack: actual=ack at cycle %0d expected=no ack", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 rdata", m0.rdata, e.rdata);
        chk("dut0 err", {31'b0, m0.err}, {31'b0, e.err});
        chk("dut0 ack cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni && m3.ack === 1'b1) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected ack: actual=ack at cycle %0d expected=no ack", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("dut3 rdata", m3.rdata, e.rdata);
        chk("dut3 err", {31'b0, m3.err}, {31'b0, e.err});
        chk("dut3 ack cycle", cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge. Presents a request, queues the expected
  // response, waits (bounded) for ack and drops req unless hold is set.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask,
                     input logic [31:0] exp_rdata, input logic exp_err, input bit hold);
    exp_t e;
    bit   got;
    int   w;
    w = (sel == 0) ? 0 : 3;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + 1 + w;
    if (sel == 0) begin
      m0.req = 1'b1; m0.wr_en = we; m0.addr = addr; m0.wdata = wdata; m0.mask = mask;
      q0.push_back(e);
    end else begin
      m3.req = 1'b1; m3.wr_en = we; m3.addr = addr; m3.wdata = wdata; m3.mask = mask;
      q3.push_back(e);
    end
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if ((sel == 0 && m0.ack === 1'b1) || (sel != 0 && m3.ack === 1'b1)) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL dut%0d ack timeout: actual=no ack expected=ack addr=%h", sel, addr);
    end
    if (!hold) begin
      if (sel == 0) m0.req = 1'b0;
      else          m3.req = 1'b0;
    end
  endtask

  task automatic rd(input int sel, input logic [31:0] addr, input logic [31:0] exp_rdata,
                    input logic exp_err);
    txn(sel, 1'b0, addr, 32'h0, 4'h0, exp_rdata, exp_err, 1'b0);
  endtask

  task automatic wr(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] mask, input logic exp_err);
    txn(sel, 1'b1, addr, wdata, mask, 32'h0, exp_err, 1'b0);
  endtask

  task automatic preload(input int sel, input logic [AW-1:0] idx, input logic [31:0] data);
    if (sel == 0) begin ld_we0 = 1'b1; ld_addr0 = idx; ld_wdata0 = data; end
    else          begin ld_we3 = 1'b1; ld_addr3 = idx; ld_wdata3 = data; end
    @(posedge clk); #1;
    ld_we0 = 1'b0;
    ld_we3 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    m0.req = 1'b0; m0.addr = '0; m0.wdata = '0; m0.mask = '0; m0.wr_en = 1'b0;
    m3.req = 1'b0; m3.addr = '0; m3.wdata = '0; m3.mask = '0; m3.wr_en = 1'b0;
    idle(3);
    chk("reset dut0 ack", {31'b0, m0.ack}, 32'h0);
    chk("reset dut0 rdata", m0.rdata, 32'h0);
    chk("reset dut0 err", {31'b0, m0.err}, 32'h0);
    chk("reset dut3 ack", {31'b0, m3.ack}, 32'h0);
    chk("reset dut3 rdata", m3.rdata, 32'h0);
    chk("reset dut3 err", {31'b0, m3.err}, 32'h0);
    rst_ni = 1'b1;
    idle(2);

    // 1: basic read
    preload(0, 4'd0, 32'h1122_3344);
    rd(0, BASE, 32'h1122_3344, 1'b0);
    idle(1);

    // 2: masked write then read back
    preload(0, 4'd1, 32'h0000_0000);
    wr(0, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd(0, BASE + 32'h4, 32'h00BB_00DD, 1'b0);
    wr(0, BASE + 32'h4, 32'h1234_5678, 4'b0000, 1'b0);
    rd(0, BASE + 32'h4, 32'h00BB_00DD, 1'b0);
    idle(1);

    // 3: wait states
    preload(3, 4'd0, 32'hCAFE_F00D);
    rd(3, BASE, 32'hCAFE_F00D, 1'b0);
    idle(2);
    wr(3, BASE + 32'h8, 32'h5555_5555, 4'b1111, 1'b0);
    txn(3, 1'b0, BASE + 32'h8, 32'h0, 4'h0, 32'h5555_5555, 1'b0, 1'b1);
    rd(3, BASE, 32'hCAFE_F00D, 1'b0);
    idle(2);

    // 4: eight back-to-back reads with req held high
    for (int i = 0; i < 8; i++) preload(0, AW'(8 + i), 32'h1000_0000 | 32'(i * 32'h0101));
    for (int i = 0; i < 8; i++)
      txn(0, 1'b0, BASE + 32'(32 + 4 * i), 32'h0, 4'h0, 32'h1000_0000 | 32'(i * 32'h0101),
          1'b0, (i != 7));
    idle(1);

    // 5: out-of-range accesses
    rd(0, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b1);
    rd(0, BASE + 32'(DEPTH * 4), 32'hDEAD_BEEF, 1'b1);
    wr(0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    wr(0, BASE + 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'b1111, 1'b1);
    rd(0, BASE, 32'h1122_3344, 1'b0);
    rd(0, BASE + 32'h3C, 32'h1000_0707, 1'b0);
    idle(1);

    // 6a: reset during WAIT aborts a write (word 2 of dut3 holds 5555_5555)
    m3.req = 1'b1; m3.wr_en = 1'b1; m3.addr = BASE + 32'h8; m3.wdata = 32'h0BAD_0BAD; m3.mask = 4'hF;
    @(posedge clk); #1;
    m3.req = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("reset in wait ack", {31'b0, m3.ack}, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle(6);
    rd(3, BASE + 32'h8, 32'h5555_5555, 1'b0);
    idle(1);

    // 6b: preload and core write to the same word in the same cycle
    ld_we0 = 1'b1; ld_addr0 = 4'd5; ld_wdata0 = 32'h7777_8888;
    wr(0, BASE + 32'h14, 32'h9999_AAAA, 4'b1111, 1'b0);
    ld_we0 = 1'b0;
    rd(0, BASE + 32'h14, 32'h7777_8888, 1'b0);

    // 6c: read sampled alongside a preload of that word sees the old value
    preload(0, 4'd6, 32'h0101_0101);
    ld_we0 = 1'b1; ld_addr0 = 4'd6; ld_wdata0 = 32'h0202_0202;
    rd(0, BASE + 32'h18, 32'h0101_0101, 1'b0);
    ld_we0 = 1'b0;
    rd(0, BASE + 32'h18, 32'h0202_0202, 1'b0);
    idle(4);

    chk("dut0 leftover expectations", 32'(q0.size()), 32'h0);
    chk("dut3 leftover expectations", 32'(q3.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
